// File: rtl/trfsm_pkg.sv
// ----------------------------------------------------------------------------
// trfsm_pkg
// Shared definitions for the configurable transition-row FSM (cfg_trfsm).
//   - row field offset functions (LSB->MSB: NextState, InValue, InMask,
//     CurState, Valid)
//   - row width and configuration chain length functions
//   - widest row index width and the run/config mode enum
// No ports (package).
// ----------------------------------------------------------------------------
package trfsm_pkg;

    // Widest row index: at most 64 transition rows.
    localparam int MaxIdxW = 6;

    // Whether the FSM is executing or held in configuration mode.
    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_CFG = 1'b1
    } trfsm_mode_e;

    function automatic int row_w(input int iw, input int sw);
        return 1 + 2 * sw + 2 * iw;
    endfunction

    function automatic int next_off();
        return 0;
    endfunction

    function automatic int val_off(input int sw);
        return sw;
    endfunction

    function automatic int mask_off(input int iw, input int sw);
        return sw + iw;
    endfunction

    function automatic int cur_off(input int iw, input int sw);
        return sw + 2 * iw;
    endfunction

    function automatic int valid_off(input int iw, input int sw);
        return 2 * sw + 2 * iw;
    endfunction

    // Rows first, then one output word per state.
    function automatic int chain_len(input int nr, input int iw, input int sw, input int ow);
        return nr * row_w(iw, sw) + (2 ** sw) * ow;
    endfunction

    // Row index width, never narrower than one bit.
    function automatic int idx_w(input int nr);
        return (nr > 1) ? $clog2(nr) : 1;
    endfunction

endpackage

// File: rtl/cfg_trfsm_if.sv
// ----------------------------------------------------------------------------
// cfg_trfsm_if
// Bundles the FSM data path and the serial configuration port of cfg_trfsm.
//   Input_i      FSM input vector
//   Output_o     Moore output vector
//   State_o      current state
//   Match_o      a row fired on the previous edge
//   MatchRow_o   index of that row
//   CfgMode_i    configuration mode
//   CfgShift_i   chain shift enable (configuration mode only)
//   CfgDataIn_i  serial chain input
//   CfgDataOut_o serial chain output
// Modports: master (drives the FSM), slave (the FSM itself).
// ----------------------------------------------------------------------------
interface cfg_trfsm_if #(
    parameter int InputWidth  = 8,
    parameter int OutputWidth = 15,
    parameter int StateWidth  = 5,
    parameter int NumRows     = 32
);
    import trfsm_pkg::*;

    localparam int IdxW = idx_w(NumRows);

    logic [InputWidth-1:0]  Input_i;
    logic [OutputWidth-1:0] Output_o;
    logic [StateWidth-1:0]  State_o;
    logic                   Match_o;
    logic [IdxW-1:0]        MatchRow_o;
    logic                   CfgMode_i;
    logic                   CfgShift_i;
    logic                   CfgDataIn_i;
    logic                   CfgDataOut_o;

    modport master (
        output Input_i, CfgMode_i, CfgShift_i, CfgDataIn_i,
        input  Output_o, State_o, Match_o, MatchRow_o, CfgDataOut_o
    );

    modport slave (
        input  Input_i, CfgMode_i, CfgShift_i, CfgDataIn_i,
        output Output_o, State_o, Match_o, MatchRow_o, CfgDataOut_o
    );

endinterface

// File: rtl/trfsm_row.sv
// ----------------------------------------------------------------------------
// trfsm_row
// Combinational match of one transition row against the current state and
// the FSM inputs.
//   row_i        packed row fields (NextState, InValue, InMask, CurState, Valid)
//   state_i      current FSM state
//   input_i      FSM inputs
//   match_o      row is valid, its CurState equals state_i and the masked
//                inputs equal the masked InValue
//   next_state_o NextState field of this row
// ----------------------------------------------------------------------------
module trfsm_row
    import trfsm_pkg::*;
#(
    parameter int InputWidth  = 8,
    parameter int StateWidth  = 5,
    localparam int RowWidth   = row_w(InputWidth, StateWidth)
) (
    input  logic [RowWidth-1:0]   row_i,
    input  logic [StateWidth-1:0] state_i,
    input  logic [InputWidth-1:0] input_i,
    output logic                  match_o,
    output logic [StateWidth-1:0] next_state_o
);

    logic [StateWidth-1:0] next_state;
    logic [StateWidth-1:0] cur_state;
    logic [InputWidth-1:0] in_value;
    logic [InputWidth-1:0] in_mask;
    logic                  valid;

    assign next_state = row_i[next_off() +: StateWidth];
    assign in_value   = row_i[val_off(StateWidth) +: InputWidth];
    assign in_mask    = row_i[mask_off(InputWidth, StateWidth) +: InputWidth];
    assign cur_state  = row_i[cur_off(InputWidth, StateWidth) +: StateWidth];
    assign valid      = row_i[valid_off(InputWidth, StateWidth)];

    // An all-zero mask makes the row fire unconditionally from cur_state.
    assign match_o = valid
                   && (cur_state == state_i)
                   && ((input_i & in_mask) == (in_value & in_mask));

    assign next_state_o = next_state;

endmodule

// File: rtl/cfg_trfsm.sv
// ----------------------------------------------------------------------------
// cfg_trfsm
// Transition-row FSM whose transition table and Moore output table live in
// one serially loaded configuration chain.
//   Clk_i    sole clock, rising edge
//   Reset_i  synchronous active-high reset; clears chain, state and flags
//   bus      cfg_trfsm_if.slave: Input_i, Output_o, State_o, Match_o,
//            MatchRow_o, CfgMode_i, CfgShift_i, CfgDataIn_i, CfgDataOut_o
// Optional feature: define CFG_TRFSM_READBACK_EN to expose chain bit 0 on
// CfgDataOut_o; otherwise CfgDataOut_o is tied low.
// ----------------------------------------------------------------------------
module cfg_trfsm
    import trfsm_pkg::*;
#(
    parameter int InputWidth  = 8,
    parameter int OutputWidth = 15,
    parameter int StateWidth  = 5,
    parameter int NumRows     = 32
) (
    input logic        Clk_i,
    input logic        Reset_i,
    cfg_trfsm_if.slave bus
);

    localparam int RowWidth  = row_w(InputWidth, StateWidth);
    localparam int ChainLen  = chain_len(NumRows, InputWidth, StateWidth, OutputWidth);
    localparam int IdxW      = idx_w(NumRows);
    localparam int NumStates = 2 ** StateWidth;
    localparam int OutBase   = NumRows * RowWidth;

    logic [ChainLen-1:0]   chain_reg;
    logic [StateWidth-1:0] state_reg;
    logic                  match_reg;
    logic [IdxW-1:0]       match_row_reg;
    trfsm_mode_e           mode_reg;

    logic [NumRows-1:0]    row_match;
    logic [StateWidth-1:0] row_next  [NumRows];
    logic [OutputWidth-1:0] out_table [NumStates];

    logic                  any_match;
    logic [IdxW-1:0]       win_idx;
    logic [StateWidth-1:0] win_next;

    genvar gi;
    generate
        for (gi = 0; gi < NumRows; gi++) begin : g_row
            trfsm_row #(
                .InputWidth (InputWidth),
                .StateWidth (StateWidth)
            ) u_row (
                .row_i        (chain_reg[gi*RowWidth +: RowWidth]),
                .state_i      (state_reg),
                .input_i      (bus.Input_i),
                .match_o      (row_match[gi]),
                .next_state_o (row_next[gi])
            );
        end

        for (gi = 0; gi < NumStates; gi++) begin : g_out
            assign out_table[gi] = chain_reg[OutBase + gi*OutputWidth +: OutputWidth];
        end
    endgenerate

    // Scan from the top row down so the lowest matching index is the last
    // one written and therefore wins.
    always_comb begin
        any_match = 1'b0;
        win_idx   = '0;
        win_next  = state_reg;
        for (int i = NumRows - 1; i >= 0; i--) begin
            if (row_match[i]) begin
                any_match = 1'b1;
                win_idx   = IdxW'(i);
                win_next  = row_next[i];
            end
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            chain_reg     <= '0;
            state_reg     <= '0;
            match_reg     <= 1'b0;
            match_row_reg <= '0;
            mode_reg      <= MODE_RUN;
        end else if (bus.CfgMode_i) begin
            // Hold the FSM parked in state 0 while the table is rewritten;
            // MatchRow_o keeps the last winner.
            mode_reg  <= MODE_CFG;
            state_reg <= '0;
            match_reg <= 1'b0;
            if (bus.CfgShift_i) begin
                chain_reg <= {bus.CfgDataIn_i, chain_reg[ChainLen-1:1]};
            end
        end else begin
            mode_reg  <= MODE_RUN;
            match_reg <= any_match;
            if (any_match) begin
                state_reg     <= win_next;
                match_row_reg <= win_idx;
            end
        end
    end

    // Moore output: depends only on registers, never on Input_i.
    assign bus.Output_o   = (mode_reg == MODE_CFG) ? '0 : out_table[state_reg];
    assign bus.State_o    = state_reg;
    assign bus.Match_o    = match_reg;
    assign bus.MatchRow_o = match_row_reg;

`ifdef CFG_TRFSM_READBACK_EN
    assign bus.CfgDataOut_o = chain_reg[0];
`else
    assign bus.CfgDataOut_o = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_trfsm.sv
// ----------------------------------------------------------------------------
// tb_cfg_trfsm
// Randomised self-checking bench for cfg_trfsm (default parameters).
// Stimulus pushes the expected post-edge outputs into a queue; a monitor pops
// and compares one entry per clock. Expected values come from a row/table
// model of the FSM that is loaded alongside the DUT's serial chain.
// Define CFG_TRFSM_READBACK_EN to also check serial readback.
// ----------------------------------------------------------------------------
module tb_cfg_trfsm;

    localparam int IW   = 8;
    localparam int OW   = 15;
    localparam int SW   = 5;
    localparam int NR   = 32;
    localparam int NS   = 32;
    localparam int IDXW = 5;
    localparam int RW   = 1 + 2*SW + 2*IW;
    localparam int L    = NR*RW + NS*OW;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    cfg_trfsm_if #(.InputWidth(IW), .OutputWidth(OW), .StateWidth(SW), .NumRows(NR)) tb_if ();

    cfg_trfsm #(
        .InputWidth  (IW),
        .OutputWidth (OW),
        .StateWidth  (SW),
        .NumRows     (NR)
    ) dut (
        .Clk_i   (clk),
        .Reset_i (rst),
        .bus     (tb_if)
    );

    typedef struct {
        logic [SW-1:0]   st;
        logic [OW-1:0]   out;
        logic            m;
        logic [IDXW-1:0] row;
        int              tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int step_no = 0;
    int nz_cnt = 0;
    logic last_dout;

    // Reference model: rows and output table, plus FSM status.
    logic          m_valid [NR];
    logic [SW-1:0] m_cur   [NR];
    logic [SW-1:0] m_next  [NR];
    logic [IW-1:0] m_mask  [NR];
    logic [IW-1:0] m_val   [NR];
    logic [OW-1:0] m_out   [NS];
    logic [SW-1:0] m_state;
    logic          m_match;
    logic [IDXW-1:0] m_row;
    logic          m_cfg;

    // Staging table for the next load.
    logic          s_valid [NR];
    logic [SW-1:0] s_cur   [NR];
    logic [SW-1:0] s_next  [NR];
    logic [IW-1:0] s_mask  [NR];
    logic [IW-1:0] s_val   [NR];
    logic [OW-1:0] s_out   [NS];

`ifdef CFG_TRFSM_READBACK_EN
    logic [L-1:0] rb_seq;
`endif

    function automatic void check(input string name, input int tag,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, tag, act, exp);
        end
    endfunction

    function automatic void model_step(input logic r, input logic mode, input logic [IW-1:0] in);
        int win;
        win = -1;
        if (r) begin
            for (int i = 0; i < NR; i++) begin
                m_valid[i] = 1'b0; m_cur[i] = '0; m_next[i] = '0; m_mask[i] = '0; m_val[i] = '0;
            end
            for (int s = 0; s < NS; s++) m_out[s] = '0;
            m_state = '0; m_match = 1'b0; m_row = '0; m_cfg = 1'b0;
        end else if (mode) begin
            m_state = '0; m_match = 1'b0; m_cfg = 1'b1;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (win < 0 && m_valid[i] && m_cur[i] == m_state
                    && ((in & m_mask[i]) == (m_val[i] & m_mask[i])))
                    win = i;
            end
            m_cfg = 1'b0;
            if (win >= 0) begin
                m_state = m_next[win]; m_match = 1'b1; m_row = IDXW'(win);
            end else begin
                m_match = 1'b0;
            end
        end
    endfunction

    // One clock of stimulus: drive on the falling edge, predict the result of
    // the following rising edge and queue it for the monitor.
    task automatic step(input logic r, input logic mode, input logic shift,
                        input logic din, input logic [IW-1:0] in);
        exp_t e;
        @(negedge clk);
        last_dout = tb_if.CfgDataOut_o;
        if (last_dout !== 1'b0) nz_cnt++;
        rst = r;
        tb_if.CfgMode_i   = mode;
        tb_if.CfgShift_i  = shift;
        tb_if.CfgDataIn_i = din;
        tb_if.Input_i     = in;
        model_step(r, mode, in);
        step_no++;
        e.st  = m_state;
        e.out = m_cfg ? '0 : m_out[m_state];
        e.m   = m_match;
        e.row = m_row;
        e.tag = step_no;
        exp_q.push_back(e);
    endtask

    // Serialise the staging table (first bit in ends up at chain bit 0).
    task automatic load_table();
        logic [L-1:0] img;
        img = '0;
        for (int r = 0; r < NR; r++) begin
            img[r*RW +: SW]             = s_next[r];
            img[r*RW + SW +: IW]        = s_val[r];
            img[r*RW + SW + IW +: IW]   = s_mask[r];
            img[r*RW + SW + 2*IW +: SW] = s_cur[r];
            img[r*RW + 2*SW + 2*IW]     = s_valid[r];
        end
        for (int s = 0; s < NS; s++) img[NR*RW + s*OW +: OW] = s_out[s];
        for (int k = 0; k < L; k++) step(1'b0, 1'b1, 1'b1, img[k], IW'($urandom));
        for (int r = 0; r < NR; r++) begin
            m_valid[r] = s_valid[r]; m_cur[r] = s_cur[r]; m_next[r] = s_next[r];
            m_mask[r]  = s_mask[r];  m_val[r] = s_val[r];
        end
        for (int s = 0; s < NS; s++) m_out[s] = s_out[s];
    endtask

    task automatic set_row(input int r, input logic v, input int cur, input logic [IW-1:0] mask,
                           input logic [IW-1:0] val, input int nxt);
        s_valid[r] = v; s_cur[r] = SW'(cur); s_mask[r] = mask; s_val[r] = val; s_next[r] = SW'(nxt);
    endtask

    // Monitor: one queued expectation per rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("state",     mon_e.tag, 32'(tb_if.State_o),    32'(mon_e.st));
            check("output",    mon_e.tag, 32'(tb_if.Output_o),   32'(mon_e.out));
            check("match",     mon_e.tag, 32'(tb_if.Match_o),    32'(mon_e.m));
            check("match_row", mon_e.tag, 32'(tb_if.MatchRow_o), 32'(mon_e.row));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic md;
        logic sh;
        tb_if.Input_i = '0; tb_if.CfgMode_i = 1'b0; tb_if.CfgShift_i = 1'b0; tb_if.CfgDataIn_i = 1'b0;

        // Reset for two cycles, then confirm the cleared state.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        nz_cnt = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        check("reset_dout", step_no, 32'(last_dout), 32'd0);

        // Directed table: basic transition, priority, no-match, self-loop.
        for (int r = 0; r < NR; r++) set_row(r, 1'b0, 0, '0, '0, 0);
        set_row(0, 1'b1, 0, 8'h01, 8'h01, 1);
        set_row(1, 1'b1, 1, 8'h02, 8'h02, 2);
        set_row(2, 1'b0, 2, 8'h00, 8'h00, 7);
        set_row(3, 1'b1, 2, 8'h00, 8'hFF, 4);
        set_row(5, 1'b1, 4, 8'hFF, 8'h5A, 9);
        set_row(6, 1'b1, 4, 8'h80, 8'h80, 10);
        set_row(7, 1'b1, 2, 8'h00, 8'h00, 9);
        set_row(8, 1'b1, 9, 8'h00, 8'h00, 9);
        for (int r = 10; r < NR; r++)
            set_row(r, 1'($urandom), int'($urandom_range(10, 31)), IW'($urandom & $urandom),
                    IW'($urandom), int'($urandom_range(0, 31)));
        for (int s = 0; s < NS; s++) s_out[s] = OW'($urandom) | 15'h0100;
        s_out[1] = 15'h0001;
        load_table();

        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);   // leave config: state 0, no match
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h01);   // row 0 -> state 1
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFD);   // masked bit clear -> hold
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h02);   // row 1 -> state 2
        step(1'b0, 1'b0, 1'b0, 1'b0, IW'($urandom)); // rows 3 and 7 both match
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h5B);   // near miss on full mask
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A);   // row 5 -> state 9
        step(1'b0, 1'b0, 1'b0, 1'b0, IW'($urandom)); // self-loop
        step(1'b0, 1'b0, 1'b0, 1'b0, IW'($urandom));
        step(1'b0, 1'b1, 1'b0, 1'b1, IW'($urandom)); // config mode mid-run
        step(1'b0, 1'b1, 1'b0, 1'b0, IW'($urandom));
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);   // back to run in state 0
        step(1'b0, 1'b0, 1'b1, 1'b1, 8'h01);   // shift ignored outside config
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h02);
        step(1'b0, 1'b0, 1'b1, 1'b1, IW'($urandom));
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);   // row 6 -> random region
        for (int k = 0; k < 60; k++) step(1'b0, 1'b0, 1'($urandom), 1'($urandom), IW'($urandom));

        // Reset wins over config shifting; empty table never matches.
        step(1'b1, 1'b1, 1'b1, 1'b1, IW'($urandom));
        step(1'b1, 1'b1, 1'b1, 1'b1, IW'($urandom));
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("reset_prio_dout", step_no, 32'(last_dout), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, IW'($urandom));

        // Fully random table with occasional config pulses.
        for (int r = 0; r < NR; r++)
            set_row(r, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                    IW'($urandom & $urandom & $urandom), IW'($urandom), int'($urandom_range(0, 7)));
        for (int s = 0; s < NS; s++) s_out[s] = OW'($urandom);
        load_table();
        for (int k = 0; k < 400; k++) begin
            md = ($urandom_range(0, 19) == 0);
            sh = md ? 1'b0 : 1'($urandom);
            step(1'b0, md, sh, 1'($urandom), IW'($urandom));
        end

`ifdef CFG_TRFSM_READBACK_EN
        begin
            int bad_bits;
            int first_bad;
            bad_bits = 0;
            first_bad = -1;
            for (int k = 0; k < L; k++) begin
                rb_seq[k] = 1'($urandom);
                step(1'b0, 1'b1, 1'b1, rb_seq[k], '0);
            end
            for (int k = 0; k < L; k++) begin
                step(1'b0, 1'b1, 1'b1, 1'($urandom), '0);
                if (last_dout !== rb_seq[k]) begin
                    bad_bits++;
                    if (first_bad < 0) first_bad = k;
                end
            end
            check("readback_wrong_bits", first_bad, 32'(bad_bits), 32'd0);
        end
`else
        check("dout_tied_low_nonzero_cycles", step_no, 32'(nz_cnt), 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", step_no, 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
